// File: rtl/pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pattern_sequencer
// Function : Walks a one/two-hot 8-bit half-step pattern toward a 4-bit target
//            position, taking one half-step every STEP_DIV enabled clocks.
// Revision : 1.0
// ============================================================================
module pattern_sequencer #(
    parameter int STEP_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] target,
    input  logic       target_valid,
    output logic       target_ready,
    input  logic       enable,
    output logic [7:0] pattern,
    output logic [3:0] position,
    output logic       busy,
    output logic       done
);

    localparam int             c_DIV_W   = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(STEP_DIV - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           pos_q, pos_d;
    logic [7:0]           pattern_q, pattern_d;
    logic [c_DIV_W-1:0]   div_q, div_d;
    logic [3:0]           tgt_q, tgt_d;
    logic                 done_q, done_d;
    logic [3:0]           w_pos_step;

    // Odd codes light one coil bit, even codes light the pair straddling it.
    function automatic logic [7:0] encode(input logic [3:0] p);
        logic [7:0] r;
        r = 8'h00;
        if (p[0]) begin
            r[p[3:1]] = 1'b1;
        end else if (p != 4'd0) begin
            r[p[3:1]]        = 1'b1;
            r[p[3:1] - 3'd1] = 1'b1;
        end
        return r;
    endfunction

    assign target_ready = (state_q == S_IDLE) && !reset;
    assign w_pos_step   = (tgt_q > pos_q) ? (pos_q + 4'd1) : (pos_q - 4'd1);

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        pattern_d = pattern_q;
        div_d     = div_q;
        tgt_d     = tgt_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (target_valid && target_ready) begin
                    if (target == pos_q) begin
                        done_d = 1'b1;
                    end else begin
                        tgt_d   = target;
                        div_d   = '0;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (enable) begin
                    if (div_q == c_DIV_MAX) begin
                        div_d     = '0;
                        pos_d     = w_pos_step;
                        pattern_d = encode(w_pos_step);
                        if (w_pos_step == tgt_q) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        div_d = div_q + c_DIV_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pos_q     <= 4'd0;
            pattern_q <= 8'h00;
            div_q     <= '0;
            tgt_q     <= 4'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            pattern_q <= pattern_d;
            div_q     <= div_d;
            tgt_q     <= tgt_d;
            done_q    <= done_d;
        end
    end

    assign pattern  = pattern_q;
    assign position = pos_q;
    assign busy     = (state_q == S_RUN);
    assign done     = done_q;

endmodule
`default_nettype wire
